spfs_flash_resp: RTL and testbench

SPFS_FLASH_RESP -- requirements
Module: spfs_flash_resp

---
 rtl/spfs_flash_resp.sv | 218 +++++++++++++++++++++
 tb/tb_spfs_flash_resp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spfs_flash_resp.sv
// spfs_flash_resp: SPI-flash style slave responder (SPI mode 0).
// Samples the SPI pins into the clk_i domain and decodes three commands:
// READ (0x03), which streams bytes from a backing memory with one-byte
// prefetch; JEDEC ID (0x9F); and READ STATUS (0x05).
// Any other command is ignored until chip select rises.
module spfs_flash_resp #(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spfs_clk_i,
    input  logic        spfs_cs_i,
    input  logic        spfs_mosi_i,
    output logic        spfs_miso_o,
    output logic        mem_rd_o,
    output logic [23:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_JDID = 8'h9F;
    localparam logic [7:0] CMD_STAT = 8'h05;

    state_t      state_q, state_d;
    logic [2:0]  sclk_q, cs_q;
    logic [1:0]  mosi_q;
    logic [1:0]  settle_q;
    logic        armed_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [6:0]  shift_q;
    logic [23:0] addr_q;
    logic [7:0]  tx_q, prefetch_q;
    logic        miso_q, mem_rd_q, rd_pend_q, first_q;

    logic cs_rise, cs_fall_raw, cs_fall, cs_edge;
    logic sclk_rise, sclk_fall, mosi_s, bit_done, tx_state;
    logic [7:0] cmd_byte;

    // CS edges take priority: an SCLK edge seen in the same cycle is discarded.
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign cs_fall_raw = ~cs_q[1] & cs_q[2];
    assign cs_edge     = cs_rise | cs_fall_raw;
    assign cs_fall     = cs_fall_raw & armed_q;
    assign sclk_rise   = sclk_q[1] & ~sclk_q[2] & ~cs_edge;
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2] & ~cs_edge;
    assign mosi_s      = mosi_q[1];
    assign bit_done    = sclk_rise & (bit_cnt_q == 3'd7);
    assign cmd_byte    = {shift_q, mosi_s};
    assign tx_state    = (state_q == DATA) || (state_q == ID) || (state_q == STAT);
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = addr_q;

    function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            default: return JEDEC_ID[7:0];
        endcase
    endfunction

    // Two-flop synchronisers plus a third stage on SCLK and CS for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spfs_clk_i};
            cs_q   <= {cs_q[1:0], spfs_cs_i};
            mosi_q <= {mosi_q[0], spfs_mosi_i};
        end
    end

    // Arm CS-fall detection only once the chain holds real pin samples and CS is high,
    // so a CS already low when reset releases cannot start a transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else if (settle_q != 2'd3) begin
            settle_q <= settle_q + 2'd1;
        end else if (cs_q[1] && cs_q[2]) begin
            armed_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic: CS rise aborts from anywhere, commands decode on byte completion.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (cs_fall) state_d = CMD;
        end else if (bit_done) begin
            case (state_q)
                CMD: begin
                    case (cmd_byte)
                        CMD_READ: state_d = ADDR;
                        CMD_JDID: state_d = ID;
                        CMD_STAT: state_d = STAT;
                        default:  state_d = IGNORE;
                    endcase
                end
                ADDR:    if (byte_cnt_q == 2'd2) state_d = DATA;
                default: ;
            endcase
        end
    end

    // Datapath: bit/byte counters, address shift, memory strobes and TX shifting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 7'd0;
            addr_q     <= 24'd0;
            tx_q       <= 8'd0;
            prefetch_q <= 8'd0;
            miso_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            rd_pend_q <= mem_rd_q;
            if (cs_rise) begin
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
                rd_pend_q <= 1'b0;
                first_q   <= 1'b0;
            end else if (state_q == IDLE) begin
                if (cs_fall) begin
                    bit_cnt_q  <= 3'd0;
                    byte_cnt_q <= 2'd0;
                    shift_q    <= 7'd0;
                    addr_q     <= 24'd0;
                    tx_q       <= 8'd0;
                    miso_q     <= 1'b0;
                    first_q    <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    shift_q   <= {shift_q[5:0], mosi_s};
                end
                // MISO changes on the falling edge so the master samples a stable bit.
                if (sclk_fall && tx_state) begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end
                case (state_q)
                    CMD: if (bit_done) begin
                        byte_cnt_q <= 2'd0;
                        if (cmd_byte == CMD_JDID) begin
                            tx_q       <= jedec_byte(2'd0);
                            byte_cnt_q <= 2'd1;
                        end else if (cmd_byte == CMD_STAT) begin
                            tx_q <= STATUS_VAL;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) addr_q <= {addr_q[22:0], mosi_s};
                        if (bit_done) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                mem_rd_q <= 1'b1;
                                first_q  <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        // Prefetch the following byte while the current one shifts out.
                        if (sclk_rise && bit_cnt_q == 3'd0) begin
                            addr_q   <= addr_q + 24'd1;
                            mem_rd_q <= 1'b1;
                        end
                        if (bit_done) tx_q <= prefetch_q;
                        if (rd_pend_q) begin
                            if (first_q) begin
                                tx_q    <= mem_rdata_i;
                                first_q <= 1'b0;
                            end else begin
                                prefetch_q <= mem_rdata_i;
                            end
                        end
                    end
                    ID: if (bit_done) begin
                        tx_q       <= jedec_byte(byte_cnt_q);
                        byte_cnt_q <= (byte_cnt_q == 2'd2) ? 2'd0 : byte_cnt_q + 2'd1;
                    end
                    STAT: if (bit_done) tx_q <= STATUS_VAL;
                    default: ;
                endcase
            end
        end
    end

    // FSM outputs: MISO only driven in the byte-returning states.
    always_comb begin
        busy_o      = (state_q != IDLE);
        spfs_miso_o = 1'b0;
        if (tx_state) spfs_miso_o = miso_q;
    end

endmodule

// File: tb/tb_spfs_flash_resp.sv
// Directed testbench for spfs_flash_resp: drives an SPI mode-0 master with
// SCLK at 1/16 of clk_i and models a memory returning addr[7:0].
module tb_spfs_flash_resp;

    localparam int CLK_P = 10;
    localparam int HALF  = 80;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        spfs_clk_i;
    logic        spfs_cs_i;
    logic        spfs_mosi_i;
    logic        spfs_miso_o;
    logic        mem_rd_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_rdata_i = 8'hA5;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_wide  = 0;
    logic        mem_rd_prev = 1'b0;
    logic [23:0] rd_log[$];
    logic [7:0]  rx_buf [0:7];

    spfs_flash_resp dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .spfs_clk_i  (spfs_clk_i),
        .spfs_cs_i   (spfs_cs_i),
        .spfs_mosi_i (spfs_mosi_i),
        .spfs_miso_o (spfs_miso_o),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    always #(CLK_P/2) clk_i = ~clk_i;

    // Memory model: data valid only in the cycle after the strobe; logs strobes.
    always @(posedge clk_i) begin
        mem_rdata_i <= mem_rd_o ? mem_addr_o[7:0] : 8'hA5;
        mem_rd_prev <= mem_rd_o;
        if (mem_rd_o) rd_log.push_back(mem_addr_o);
        if (mem_rd_o && mem_rd_prev) rd_wide <= rd_wide + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < rd_log.size()) return 32'(rd_log[idx]);
        return 32'hDEAD_BEEF;
    endfunction

    // Shift nbits of tx MSB-first; capture MISO just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spfs_mosi_i = tx[i];
            #HALF;
            rx[i] = spfs_miso_o;
            spfs_clk_i = 1'b1;
            #HALF;
            spfs_clk_i = 1'b0;
        end
    endtask

    // Lower CS, send command (+ optional address), clock nbytes dummy bytes; CS left low.
    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input bit has_addr,
                        input int nbytes);
        logic [7:0] dummy;
        spfs_cs_i = 1'b0;
        #(8*CLK_P);
        spi_bits(cmd, 8, dummy);
        if (has_addr) begin
            spi_bits(addr[23:16], 8, dummy);
            spi_bits(addr[15:8], 8, dummy);
            spi_bits(addr[7:0], 8, dummy);
        end
        for (int b = 0; b < nbytes; b++) spi_bits(8'h00, 8, rx_buf[b]);
    endtask

    task automatic cs_end();
        #HALF;
        spfs_cs_i   = 1'b1;
        spfs_mosi_i = 1'b0;
        #(20*CLK_P);
    endtask

    initial begin
        logic [7:0] tmp;
        int         n_before;
        logic [7:0] exp_wrap [0:3];
        logic [7:0] exp_id [0:3];
        exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_id   = '{8'hEF, 8'h40, 8'h18, 8'hEF};

        rst_n_i     = 1'b0;
        spfs_cs_i   = 1'b1;
        spfs_clk_i  = 1'b0;
        spfs_mosi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_miso", 32'(spfs_miso_o), 0);
        check("rst_mem_rd", 32'(mem_rd_o), 0);
        check("rst_mem_addr", 32'(mem_addr_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk_i);

        // READ at 0x000010, four bytes
        rd_log.delete();
        xfer(8'h03, 24'h000010, 1'b1, 4);
        check("rd10_busy_during", 32'(busy_o), 1);
        cs_end();
        for (int i = 0; i < 4; i++) check($sformatf("rd10_b%0d", i), 32'(rx_buf[i]), 32'h10 + i);
        check("rd10_pulses_4or5", 32'(rd_log.size() >= 4 && rd_log.size() <= 5), 1);
        check("rd10_first_addr", log_at(0), 32'h000010);
        check("rd10_busy_after", 32'(busy_o), 0);

        // READ across the top of the address space
        rd_log.delete();
        xfer(8'h03, 24'hFFFFFE, 1'b1, 4);
        cs_end();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_b%0d", i), 32'(rx_buf[i]), 32'(exp_wrap[i]));
            check($sformatf("wrap_addr%0d", i), log_at(i), (i < 2) ? 32'hFFFFFE + i : 32'(i - 2));
        end

        // JEDEC ID with wrap to the first byte
        rd_log.delete();
        xfer(8'h9F, 24'h0, 1'b0, 4);
        cs_end();
        for (int i = 0; i < 4; i++) check($sformatf("id_b%0d", i), 32'(rx_buf[i]), 32'(exp_id[i]));
        check("id_no_mem_rd", 32'(rd_log.size()), 0);

        // Status register, then an unknown command
        xfer(8'h05, 24'h0, 1'b0, 2);
        cs_end();
        check("stat_b0", 32'(rx_buf[0]), 32'h00);
        check("stat_b1", 32'(rx_buf[1]), 32'h00);
        rd_log.delete();
        xfer(8'hAB, 24'h0, 1'b0, 2);
        cs_end();
        check("ign_b0", 32'(rx_buf[0]), 32'h00);
        check("ign_b1", 32'(rx_buf[1]), 32'h00);
        check("ign_no_mem_rd", 32'(rd_log.size()), 0);

        // Abort mid-byte: CS rises after 3 bits of the second data byte
        rd_log.delete();
        xfer(8'h03, 24'h000040, 1'b1, 1);
        spi_bits(8'h00, 3, tmp);
        @(negedge clk_i);
        spfs_cs_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_idle_3clk", 32'(busy_o), 0);
        check("abort_miso", 32'(spfs_miso_o), 0);
        n_before = rd_log.size();
        #(20*CLK_P);
        check("abort_no_more_rd", 32'(rd_log.size()), 32'(n_before));
        check("abort_first_byte", 32'(rx_buf[0]), 32'h40);
        rd_log.delete();
        xfer(8'h03, 24'h000020, 1'b1, 2);
        cs_end();
        check("after_abort_b0", 32'(rx_buf[0]), 32'h20);
        check("after_abort_b1", 32'(rx_buf[1]), 32'h21);
        check("after_abort_addr", log_at(0), 32'h000020);

        // Reset pulsed mid-ADDR with CS held low
        spfs_cs_i = 1'b0;
        #(8*CLK_P);
        spi_bits(8'h03, 8, tmp);
        spi_bits(8'h00, 8, tmp);
        spi_bits(8'h00, 4, tmp);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("midrst_miso", 32'(spfs_miso_o), 0);
        check("midrst_mem_rd", 32'(mem_rd_o), 0);
        check("midrst_mem_addr", 32'(mem_addr_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        rst_n_i = 1'b1;
        n_before = rd_log.size();
        for (int b = 0; b < 4; b++) spi_bits(8'h03, 8, tmp);
        check("postrst_no_rd", 32'(rd_log.size()), 32'(n_before));
        check("postrst_idle", 32'(busy_o), 0);
        cs_end();
        rd_log.delete();
        xfer(8'h03, 24'h000030, 1'b1, 1);
        cs_end();
        check("postrst_read_b0", 32'(rx_buf[0]), 32'h30);
        check("postrst_read_addr", log_at(0), 32'h000030);

        check("mem_rd_single_cycle", 32'(rd_wide), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
